// File: rtl/dtc_request_detector.sv
// Packet detector on the XCVR word stream: frames SOP + 8 payload words, checks the
// XOR checksum and raises busy_start for packet types enabled in ACCEPT_MASK.
module dtc_request_detector #(
  parameter int          GAP_TIMEOUT = 16,
  parameter logic [15:0] ACCEPT_MASK = 16'h0015
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_k,
  input  logic        cnt_clear,
  output logic        busy_start,
  output logic        pkt_valid,
  output logic [3:0]  pkt_type,
  output logic [15:0] pkt_word0,
  output logic        err_crc,
  output logic        err_trunc,
  output logic [15:0] req_cnt,
  output logic [15:0] err_cnt
);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic {IDLE, PAYLOAD} state_t;
  typedef struct packed {
    logic good;
    logic bad;
    logic trunc;
  } evt_t;

  state_t        state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [15:0]   acc, acc_nxt;
  logic [15:0]   word0, word0_nxt;
  logic [GW-1:0] gap, gap_nxt;
  evt_t          evt;
  logic          sop, data_word, busy_nxt;

  assign sop       = rx_valid && (rx_k == 2'b01) && (rx_data[7:0] == 8'h1C);
  assign data_word = rx_valid && (rx_k == 2'b00);
  // word0 already holds this packet's first payload word by the time word 7 lands
  assign busy_nxt  = evt.good && ACCEPT_MASK[word0[7:4]];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    acc_nxt   = acc;
    gap_nxt   = gap;
    word0_nxt = word0;
    evt       = '0;
    case (state)
      IDLE: begin
        if (sop) begin
          state_nxt = PAYLOAD;
          idx_nxt   = '0;
          acc_nxt   = '0;
          gap_nxt   = '0;
        end
      end
      PAYLOAD: begin
        if (sop) begin
          evt.trunc = 1'b1;
          idx_nxt   = '0;
          acc_nxt   = '0;
          gap_nxt   = '0;
        end else if (data_word) begin
          gap_nxt = '0;
          idx_nxt = idx + 3'd1;
          acc_nxt = acc ^ rx_data;
          if (idx == 3'd0) word0_nxt = rx_data;
          if (idx == 3'd7) begin
            state_nxt = IDLE;
            evt.good  = (acc == rx_data);
            evt.bad   = (acc != rx_data);
          end
        end else if (rx_valid) begin
          evt.trunc = 1'b1;
          state_nxt = IDLE;
        end else if (gap == GW'(GAP_TIMEOUT - 1)) begin
          evt.trunc = 1'b1;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
      gap   <= '0;
      word0 <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
      gap   <= gap_nxt;
      word0 <= word0_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_start <= 1'b0;
      pkt_valid  <= 1'b0;
      err_crc    <= 1'b0;
      err_trunc  <= 1'b0;
      pkt_type   <= '0;
      pkt_word0  <= '0;
    end else begin
      busy_start <= busy_nxt;
      pkt_valid  <= evt.good;
      err_crc    <= evt.bad;
      err_trunc  <= evt.trunc;
      if (evt.good) begin
        pkt_type  <= word0[7:4];
        pkt_word0 <= word0;
      end
    end
  end

  // Counters advance on the same edge as the pulse so they read updated alongside it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_cnt <= '0;
      err_cnt <= '0;
    end else if (cnt_clear) begin
      req_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (busy_nxt && req_cnt != 16'hFFFF) req_cnt <= req_cnt + 16'd1;
      if ((evt.bad || evt.trunc) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dtc_request_detector.sv
// Directed bench for dtc_request_detector: a packet-level model (collected word queue)
// is compared every cycle, plus literal spot checks on the key scenarios.
module tb_dtc_request_detector;
  localparam int          GAP_TIMEOUT = 16;
  localparam logic [15:0] ACCEPT_MASK = 16'h0015;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic [1:0]  rx_k = '0;
  logic        cnt_clear = 1'b0;
  logic        busy_start, pkt_valid, err_crc, err_trunc;
  logic [3:0]  pkt_type;
  logic [15:0] pkt_word0, req_cnt, err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;

  dtc_request_detector #(.GAP_TIMEOUT(GAP_TIMEOUT), .ACCEPT_MASK(ACCEPT_MASK)) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_k(rx_k),
    .cnt_clear(cnt_clear), .busy_start(busy_start), .pkt_valid(pkt_valid),
    .pkt_type(pkt_type), .pkt_word0(pkt_word0), .err_crc(err_crc), .err_trunc(err_trunc),
    .req_cnt(req_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: collect payload words in a queue, decide at 8 words.
  logic        m_in = 1'b0;
  logic [15:0] m_words[$];
  int          m_gap = 0;
  logic        m_bs = 0, m_pv = 0, m_ec = 0, m_et = 0;
  logic [3:0]  m_type = '0;
  logic [15:0] m_w0 = '0, m_rc = '0, m_erc = '0, m_x;
  logic        m_sop;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_in = 0; m_words.delete(); m_gap = 0;
        m_bs = 0; m_pv = 0; m_ec = 0; m_et = 0;
        m_type = '0; m_w0 = '0; m_rc = '0; m_erc = '0;
      end else begin
        m_bs = 0; m_pv = 0; m_ec = 0; m_et = 0;
        m_sop = rx_valid && rx_k == 2'b01 && rx_data[7:0] == 8'h1C;
        if (!m_in) begin
          if (m_sop) begin m_in = 1; m_words.delete(); m_gap = 0; end
        end else if (rx_valid) begin
          m_gap = 0;
          if (m_sop) begin m_et = 1; m_words.delete(); end
          else if (rx_k != 2'b00) begin m_et = 1; m_in = 0; end
          else begin
            m_words.push_back(rx_data);
            if (m_words.size() == 8) begin
              m_x = '0;
              for (int i = 0; i < 7; i++) m_x ^= m_words[i];
              if (m_x == m_words[7]) begin
                m_pv = 1; m_w0 = m_words[0]; m_type = m_w0[7:4];
                m_bs = ACCEPT_MASK[m_type];
              end else m_ec = 1;
              m_in = 0;
            end
          end
        end else begin
          m_gap++;
          if (m_gap == GAP_TIMEOUT) begin m_et = 1; m_in = 0; end
        end
        if (cnt_clear) begin m_rc = '0; m_erc = '0; end
        else begin
          if (m_bs && m_rc != 16'hFFFF) m_rc++;
          if ((m_ec || m_et) && m_erc != 16'hFFFF) m_erc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy_start", 16'(busy_start), 16'(m_bs));
      chk("pkt_valid",  16'(pkt_valid),  16'(m_pv));
      chk("err_crc",    16'(err_crc),    16'(m_ec));
      chk("err_trunc",  16'(err_trunc),  16'(m_et));
      chk("pkt_type",   16'(pkt_type),   16'(m_type));
      chk("pkt_word0",  pkt_word0,       m_w0);
      chk("req_cnt",    req_cnt,         m_rc);
      chk("err_cnt",    err_cnt,         m_erc);
    end
  end

  task automatic cyc(input logic v, input logic [1:0] k, input logic [15:0] d,
                     input logic clr = 1'b0);
    rx_valid = v; rx_k = k; rx_data = d; cnt_clear = clr;
    @(posedge clk); #1;
    rx_valid = 0; rx_k = '0; rx_data = '0; cnt_clear = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 16'h0000);
  endtask

  task automatic sop(input logic [7:0] hi = 8'h00);
    cyc(1'b1, 2'b01, {hi, 8'h1C});
  endtask

  // Payload words first..last of the standard packet w0,1111..6666,xor(^flip).
  task automatic words(input logic [15:0] w0, input int first, input int last,
                       input logic [15:0] flip = '0, input logic gaps = 1'b0,
                       input logic clr_last = 1'b0);
    logic [15:0] w[8];
    w[0] = w0; w[7] = w0;
    for (int i = 1; i < 7; i++) begin w[i] = 16'(i) * 16'h1111; w[7] ^= w[i]; end
    w[7] ^= flip;
    for (int i = first; i <= last; i++) begin
      cyc(1'b1, 2'b00, w[i], (i == 7) && clr_last);
      if (gaps && i < last) idle(2);
    end
  endtask

  initial begin
    #1 reset_n = 0;
    #20 reset_n = 1;
    @(posedge clk); #1;
    cmp_en = 1;
    chk("rst busy_start", 16'(busy_start), 16'h0);
    chk("rst pkt_type", 16'(pkt_type), 16'h0);
    chk("rst req_cnt", req_cnt, 16'h0);
    chk("rst err_cnt", err_cnt, 16'h0);

    // Junk while idle: data, stray K, non-SOP K char
    cyc(1'b1, 2'b00, 16'h1234); cyc(1'b1, 2'b10, 16'h1C00); cyc(1'b1, 2'b01, 16'h00BC);
    idle(2);
    chk("idle err_cnt", err_cnt, 16'h0);

    // Type 2 good packet; checksum word is 0x7757
    sop(8'hA5); words(16'h0020, 0, 7);
    chk("t2 busy_start", 16'(busy_start), 16'h1);
    chk("t2 pkt_valid", 16'(pkt_valid), 16'h1);
    chk("t2 pkt_type", 16'(pkt_type), 16'h2);
    chk("t2 req_cnt", req_cnt, 16'h1);
    // Type 3 SOP arrives in the busy_start cycle
    sop(); words(16'h0030, 0, 7);
    chk("t3 pkt_valid", 16'(pkt_valid), 16'h1);
    chk("t3 busy_start", 16'(busy_start), 16'h0);
    chk("t3 pkt_type", 16'(pkt_type), 16'h3);
    chk("t3 req_cnt", req_cnt, 16'h1);
    idle(1);

    // Bad checksum
    sop(); words(16'h0020, 0, 7, 16'h0001);
    chk("crc err_crc", 16'(err_crc), 16'h1);
    chk("crc busy_start", 16'(busy_start), 16'h0);
    chk("crc err_cnt", err_cnt, 16'h1);
    chk("crc pkt_type", 16'(pkt_type), 16'h3);

    // Truncated by SOP, then good DCS packet
    cyc(1'b0, 2'b00, 16'h0, 1'b1);
    sop(); words(16'h0020, 0, 2); sop();
    chk("sop err_trunc", 16'(err_trunc), 16'h1);
    words(16'h0005, 0, 7);
    chk("dcs busy_start", 16'(busy_start), 16'h1);
    chk("dcs pkt_word0", pkt_word0, 16'h0005);
    chk("dcs err_cnt", err_cnt, 16'h1);
    chk("dcs req_cnt", req_cnt, 16'h1);

    // Gap timeout: 16 idle cycles aborts, 15 does not
    sop(); words(16'h0040, 0, 1); idle(15);
    chk("gap15 err_trunc", 16'(err_trunc), 16'h0);
    idle(1);
    chk("gap16 err_trunc", 16'(err_trunc), 16'h1);
    sop(); words(16'h0040, 0, 1); idle(15); words(16'h0040, 2, 7);
    chk("gap15 busy_start", 16'(busy_start), 16'h1);
    chk("gap15 pkt_type", 16'(pkt_type), 16'h4);

    // Stray K mid-packet, then remaining words ignored in IDLE
    sop(); words(16'h0020, 0, 3); cyc(1'b1, 2'b10, 16'hBC00);
    chk("stray err_trunc", 16'(err_trunc), 16'h1);
    words(16'h0020, 4, 7);
    idle(1);
    // Packet with idle gaps between words
    sop(); words(16'h0000, 0, 7, 16'h0, 1'b1);
    chk("gapped busy_start", 16'(busy_start), 16'h1);

    // Reset mid-packet discards it silently
    sop(); words(16'h0020, 0, 4);
    reset_n = 0; @(posedge clk); #1; reset_n = 1;
    words(16'h0020, 5, 7);
    chk("postrst err_cnt", err_cnt, 16'h0);
    sop(); words(16'h0010, 0, 7);
    chk("postrst pkt_type", 16'(pkt_type), 16'h1);
    chk("postrst busy_start", 16'(busy_start), 16'h0);

    // Saturation and clear priority
    force dut.err_cnt = 16'hFFFE;
    m_erc = 16'hFFFE;
    #1 release dut.err_cnt;
    sop(); words(16'h0020, 0, 7, 16'h0100);
    chk("sat1 err_cnt", err_cnt, 16'hFFFF);
    sop(); words(16'h0020, 0, 7, 16'h0100);
    chk("sat2 err_cnt", err_cnt, 16'hFFFF);
    sop(); words(16'h0020, 0, 7, 16'h0100, 1'b0, 1'b1);
    chk("clr err_crc", 16'(err_crc), 16'h1);
    chk("clr err_cnt", err_cnt, 16'h0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
